// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with divide-by-zero detection and sign fix-up in a dedicated cycle.
module div_iter #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;

    logic             start;
    logic             eff_signed;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        exc_d      = exc_q;

        start      = ctrl_DIV && (state_q == IDLE || state_q == DONE);
        eff_signed = SIGNED_EN && signed_mode;
        dvd_neg    = eff_signed && dividend[WIDTH-1];
        dvs_neg    = eff_signed && divisor[WIDTH-1];
        dvd_mag    = dvd_neg ? -dividend : dividend;
        dvs_mag    = dvs_neg ? -divisor : divisor;

        // One extra bit keeps the shifted partial remainder exact when A's MSB is set.
        shifted    = {a_q, q_q[WIDTH-1]};
        trial      = shifted - {1'b0, m_q};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '0;
                        rem_d   = dividend;
                        exc_d   = 1'b1;
                    end else begin
                        state_d    = CALC;
                        a_d        = '0;
                        q_d        = dvd_mag;
                        m_d        = dvs_mag;
                        neg_quot_d = dvd_neg ^ dvs_neg;
                        neg_rem_d  = dvd_neg;
                        cnt_d      = CW'(WIDTH - 1);
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    a_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = shifted[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                quot_d  = neg_quot_q ? -q_q : q_q;
                rem_d   = neg_rem_q ? -a_q : a_q;
                exc_d   = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            exc_q      <= exc_d;
        end
    end

    assign quotient       = quot_q;
    assign remainder      = rem_q;
    assign data_exception = exc_q;
    assign busy           = (state_q == CALC) || (state_q == FIX);
    assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: 32-bit signed/unsigned vectors through a
// result scoreboard, multi-cycle corner sequences, and an 8-bit unsigned-only instance.
module tb_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        ctrl_div, sm;
    logic [31:0] dvd, dvs;
    logic [31:0] q, r;
    logic        busy, rdy, exc;

    logic        c8, sm8;
    logic [7:0]  dvd8, dvs8;
    logic [7:0]  q8, r8;
    logic        busy8, rdy8, exc8;

    div_iter #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_DIV(ctrl_div), .signed_mode(sm),
        .dividend(dvd), .divisor(dvs), .quotient(q), .remainder(r),
        .busy(busy), .data_resultRDY(rdy), .data_exception(exc)
    );

    div_iter #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .reset_n(reset_n), .ctrl_DIV(c8), .signed_mode(sm8),
        .dividend(dvd8), .divisor(dvs8), .quotient(q8), .remainder(r8),
        .busy(busy8), .data_resultRDY(rdy8), .data_exception(exc8)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
    } exp_t;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic        sm;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          lat;
    } vec_t;

    exp_t scb[$];
    exp_t last_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er, input logic ee);
        exp_t e;
        ctrl_div = 1'b1;
        dvd      = a;
        dvs      = b;
        sm       = s;
        e.q = eq; e.r = er; e.exc = ee;
        scb.push_back(e);
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] eq, input logic [31:0] er, input logic ee);
        @(negedge clk);
        drive32(a, b, s, eq, er, ee);
    endtask

    // Waits for the result pulse after the start edge, optionally injecting a
    // start strobe (9/3) at cycle inj_at while the divider should be busy.
    task automatic wait_result(input string name, input int exp_lat, input int inj_at);
        int   c;
        bit   seen;
        bit   busy_bad;
        exp_t e;
        @(posedge clk);
        #1 ctrl_div = 1'b0;
        c        = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && c < 100) begin
            @(negedge clk);
            c++;
            if (rdy === 1'b1) begin
                seen = 1'b1;
                if (busy !== 1'b0) busy_bad = 1'b1;
                check({name, "_latency"}, 64'(c), 64'(exp_lat));
                if (scb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_scoreboard: got result pulse, expected none pending", name);
                end else begin
                    e = scb.pop_front();
                    last_e = e;
                    check({name, "_quotient"}, 64'(q), 64'(e.q));
                    check({name, "_remainder"}, 64'(r), 64'(e.r));
                    check({name, "_exception"}, 64'(exc), 64'(e.exc));
                end
            end else if (busy !== (c < exp_lat)) begin
                busy_bad = 1'b1;
            end
            if (inj_at != 0 && c == inj_at) begin
                ctrl_div = 1'b1;
                dvd      = 32'd9;
                dvs      = 32'd3;
            end
            if (inj_at != 0 && c == inj_at + 1) ctrl_div = 1'b0;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no result pulse, expected one at cycle %0d", name, exp_lat);
        end
        check({name, "_busy_profile"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic post_check(input string name);
        @(negedge clk);
        check({name, "_pulse_width"}, 64'(rdy), 64'd0);
        check({name, "_hold_q"}, 64'(q), 64'(last_e.q));
        check({name, "_hold_r"}, 64'(r), 64'(last_e.r));
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee, input int lat);
        int c;
        bit seen;
        @(negedge clk);
        c8 = 1'b1; dvd8 = a; dvs8 = b; sm8 = 1'b1;
        @(posedge clk);
        #1 c8 = 1'b0;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (rdy8 === 1'b1) begin
                seen = 1'b1;
                check({name, "_latency"}, 64'(c), 64'(lat));
                check({name, "_quotient"}, 64'(q8), 64'(eq));
                check({name, "_remainder"}, 64'(r8), 64'(er));
                check({name, "_exception"}, 64'(exc8), 64'(ee));
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no result pulse, expected one at cycle %0d", name, lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              vecs[15];
        logic [31:0]       ua, ub;
        logic signed [31:0] sa, sbv;

        vecs[0]  = '{32'd100,         32'd7,          1'b0, 32'd14,        32'd2,          1'b0, 34};
        vecs[1]  = '{-32'sd100,       32'd7,          1'b1, -32'sd14,      -32'sd2,        1'b0, 34};
        vecs[2]  = '{32'd100,         -32'sd7,        1'b1, -32'sd14,      32'd2,          1'b0, 34};
        vecs[3]  = '{32'h8000_0000,   32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,          1'b0, 34};
        vecs[4]  = '{32'd1234,        32'd0,          1'b0, 32'd0,         32'd1234,       1'b1, 1};
        vecs[5]  = '{32'd0,           32'd5,          1'b0, 32'd0,         32'd0,          1'b0, 34};
        vecs[6]  = '{32'd3,           32'd10,         1'b1, 32'd0,         32'd3,          1'b0, 34};
        vecs[7]  = '{-32'sd3,         32'd10,         1'b1, 32'd0,         -32'sd3,        1'b0, 34};
        vecs[8]  = '{32'hFFFF_FFFF,   32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,          1'b0, 34};
        vecs[9]  = '{32'hFFFF_FFFF,   32'd16,         1'b0, 32'h0FFF_FFFF, 32'd15,         1'b0, 34};
        vecs[10] = '{32'h8000_0000,   32'hFFFF_FFFF,  1'b0, 32'd0,         32'h8000_0000,  1'b0, 34};
        vecs[11] = '{-32'sd7,         32'd0,          1'b1, 32'd0,         -32'sd7,        1'b1, 1};
        vecs[12] = '{-32'sd100,       -32'sd7,        1'b1, 32'd14,        -32'sd2,        1'b0, 34};
        vecs[13] = '{32'hFFFF_FFFE,   32'hFFFF_FFFF,  1'b0, 32'd0,         32'hFFFF_FFFE,  1'b0, 34};
        vecs[14] = '{32'hFFFF_FFFF,   32'hFFFF_FFFE,  1'b0, 32'd1,         32'd1,          1'b0, 34};

        reset_n  = 1'b0;
        ctrl_div = 1'b0; sm  = 1'b0; dvd  = '0; dvs  = '0;
        c8       = 1'b0; sm8 = 1'b0; dvd8 = '0; dvs8 = '0;

        repeat (2) @(negedge clk);
        check("reset_quotient", 64'(q), 64'd0);
        check("reset_remainder", 64'(r), 64'd0);
        check("reset_flags", 64'({busy, rdy, exc}), 64'd0);
        check("reset8_outputs", 64'({q8, r8, busy8, rdy8, exc8}), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            start32(vecs[i].dvd, vecs[i].dvs, vecs[i].sm, vecs[i].q, vecs[i].r, vecs[i].exc);
            wait_result($sformatf("vec%0d", i), vecs[i].lat, 0);
            post_check($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            ua = $urandom;
            ub = $urandom >> $urandom_range(0, 28);
            if (ub == 0) ub = 32'd3;
            start32(ua, ub, 1'b0, ua / ub, ua % ub, 1'b0);
            wait_result($sformatf("rnd_u%0d", i), 34, 0);
        end

        for (int i = 0; i < 4; i++) begin
            sa  = $signed($urandom);
            if (sa == 32'sh8000_0000) sa = 32'sd1;
            sbv = $signed(32'($urandom_range(1, 5000)));
            if ($urandom_range(0, 1) == 1) sbv = -sbv;
            start32(sa, sbv, 1'b1, sa / sbv, sa % sbv, 1'b0);
            wait_result($sformatf("rnd_s%0d", i), 34, 0);
        end

        // Start ignored while busy, then a back-to-back start from the DONE cycle.
        start32(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
        wait_result("busy_ignore", 34, 10);
        drive32(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0);
        wait_result("back_to_back", 34, 0);

        // Asynchronous reset mid-calculation aborts the operation.
        @(negedge clk);
        ctrl_div = 1'b1; dvd = 32'h1234_5678; dvs = 32'd3; sm = 1'b0;
        @(posedge clk);
        #1 ctrl_div = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_quotient", 64'(q), 64'd0);
        check("async_reset_remainder", 64'(r), 64'd0);
        check("async_reset_flags", 64'({busy, rdy, exc}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive32(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0);
        wait_result("after_reset", 34, 0);
        check("after_reset_scoreboard_empty", 64'(scb.size()), 64'd0);

        // Narrow instance with signed support disabled.
        run8("w8_255_16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 10);
        run8("w8_80_ff", 8'h80, 8'hFF, 8'd0, 8'h80, 1'b0, 10);
        run8("w8_div0", 8'd7, 8'd0, 8'd0, 8'd7, 1'b1, 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
